// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache miss controller: FSM state, request op encoding
// and the width of the main-memory latency counter.
package cache_ctrl_pkg;

  localparam int unsigned LAT_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    FILL      = 3'd2,
    REFILL    = 3'd3,
    REPLAY    = 3'd4
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

  // A simultaneous load+store request is treated as a store.
  function automatic op_t req_op(input logic we);
    return we ? OP_STORE : OP_LOAD;
  endfunction

endpackage

// File: rtl/cache_miss_controller_if.sv
// Pipeline/memory_system bus seen by the miss controller. The controller is the
// slave; the pipeline + memory_system side is the master.
interface cache_miss_controller_if;

  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        hit;
  logic        dirty;
  logic [31:0] victim_addr;

  logic        cache_re;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic        we2;
  logic        we3;
  logic        mem_wb_we;
  logic [31:0] mem_wb_addr;
  logic        stall;

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, hit, dirty, victim_addr,
    input  cache_re, cache_we, cache_addr, cache_wdata,
    input  we2, we3, mem_wb_we, mem_wb_addr, stall
  );

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, hit, dirty, victim_addr,
    output cache_re, cache_we, cache_addr, cache_wdata,
    output we2, we3, mem_wb_we, mem_wb_addr, stall
  );

endinterface

// File: rtl/latency_timer.sv
// Down-counter for fixed-latency phases: load with N-1, done while the count is 0.
// Reusable by a main-memory model as well as by the miss controller.
module latency_timer
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences cache misses: optional victim writeback, main-memory fill wait,
// a single-cycle refill strobe and a replay of the stalled access.
module cache_miss_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 20,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_miss_controller_if.slave bus,
  output logic                 err,
  output logic [CNT_W-1:0]     miss_count
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nx;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] victim_q;
  logic        wb_first;

  logic        req;
  logic        miss;
  logic        illegal;
  logic        tmr_load;
  logic        tmr_tick;
  logic        tmr_done;

  assign req      = bus.cpu_re | bus.cpu_we;
  assign miss     = (state == IDLE) && req && !bus.hit;
  assign illegal  = (state == IDLE) && bus.cpu_re && bus.cpu_we;

  // The timer is reloaded only when a latency phase is entered.
  assign tmr_load = miss || ((state == WRITEBACK) && tmr_done);
  assign tmr_tick = (state == WRITEBACK) || (state == FILL);

  latency_timer #(
    .W(LAT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (LAT_LOAD),
    .tick    (tmr_tick),
    .done    (tmr_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (miss) state_nx = bus.dirty ? WRITEBACK : FILL;
      WRITEBACK: if (tmr_done) state_nx = FILL;
      FILL:      if (tmr_done) state_nx = REFILL;
      REFILL:    state_nx = REPLAY;
      REPLAY:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= OP_LOAD;
      addr_q     <= '0;
      wdata_q    <= '0;
      victim_q   <= '0;
      wb_first   <= 1'b0;
      miss_count <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_nx;
      wb_first <= miss && bus.dirty;
      if (miss) begin
        op_q     <= req_op(bus.cpu_we);
        addr_q   <= bus.cpu_addr;
        wdata_q  <= bus.cpu_wdata;
        victim_q <= bus.victim_addr;
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      if (illegal || ((state == REPLAY) && !bus.hit)) err <= 1'b1;
    end
  end

  // Every strobe and stall is held low while reset_n is asserted.
  always_comb begin
    bus.cache_re    = 1'b0;
    bus.cache_we    = 1'b0;
    bus.cache_addr  = addr_q;
    bus.cache_wdata = wdata_q;
    bus.we2         = 1'b0;
    bus.we3         = 1'b0;
    bus.mem_wb_we   = 1'b0;
    bus.mem_wb_addr = victim_q;
    bus.stall       = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          bus.cache_re    = bus.cpu_re && !bus.cpu_we;
          bus.cache_we    = bus.cpu_we;
          bus.cache_addr  = bus.cpu_addr;
          bus.cache_wdata = bus.cpu_wdata;
          bus.stall       = miss;
        end
        WRITEBACK: begin
          bus.stall     = 1'b1;
          bus.mem_wb_we = wb_first;
        end
        FILL: begin
          bus.stall = 1'b1;
        end
        REFILL: begin
          bus.stall = 1'b1;
          bus.we2   = (op_q == OP_STORE);
          bus.we3   = (op_q == OP_LOAD);
        end
        REPLAY: begin
          bus.cache_re = (op_q == OP_LOAD);
          bus.cache_we = (op_q == OP_STORE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller with MEM_LATENCY=20: hit, clean and
// dirty misses, reset mid-fill, replay miss and simultaneous re/we.
module tb_cache_miss_controller;

  logic             clk;
  logic             reset_n;
  logic [15:0]      miss_count;
  logic             err;
  int               n_checks;
  int               n_errors;

  cache_miss_controller_if bus();

  cache_miss_controller #(
    .MEM_LATENCY (20),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .err        (err),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int          r_stall, r_end;
  int          r_we2_n, r_we2_cyc, r_we3_n, r_we3_cyc, r_wb_n, r_wb_cyc;
  logic [31:0] r_wb_addr, r_fill_addr, r_rep_addr, r_rep_wdata;
  logic        r_rep_re, r_rep_we, r_rep_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_re      = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.hit         = 1'b0;
    bus.dirty       = 1'b0;
    bus.victim_addr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Starts at cycle 0 (IDLE) and runs until the first non-stalled cycle after it.
  task automatic run_miss(input logic is_store, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic dirty_in,
                          input logic [31:0] victim, input logic replay_hit);
    bus.cpu_re      = !is_store;
    bus.cpu_we      = is_store;
    bus.cpu_addr    = addr;
    bus.cpu_wdata   = wdata;
    bus.hit         = 1'b0;
    bus.dirty       = dirty_in;
    bus.victim_addr = victim;
    r_stall = 0; r_end = -1;
    r_we2_n = 0; r_we2_cyc = -1; r_we3_n = 0; r_we3_cyc = -1; r_wb_n = 0; r_wb_cyc = -1;
    r_wb_addr = '0; r_fill_addr = '0; r_rep_addr = '0; r_rep_wdata = '0;
    r_rep_re = 1'b0; r_rep_we = 1'b0; r_rep_err = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c == 1) begin
        idle_inputs();
        bus.hit = replay_hit;
      end
      #2;
      if (bus.stall) r_stall++;
      if (bus.we2) begin r_we2_n++; r_we2_cyc = c; r_fill_addr = bus.cache_addr; end
      if (bus.we3) begin r_we3_n++; r_we3_cyc = c; r_fill_addr = bus.cache_addr; end
      if (bus.mem_wb_we) begin r_wb_n++; r_wb_cyc = c; r_wb_addr = bus.mem_wb_addr; end
      if (c > 0 && !bus.stall) begin
        r_end       = c;
        r_rep_re    = bus.cache_re;
        r_rep_we    = bus.cache_we;
        r_rep_addr  = bus.cache_addr;
        r_rep_wdata = bus.cache_wdata;
        r_rep_err   = err;
        break;
      end
      step();
    end
    step();
    idle_inputs();
  endtask

  initial begin
    int pulses;
    int stalls;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle_inputs();
    step();

    // Reset state, with a would-be miss presented during reset
    bus.cpu_re = 1'b1;
    #2;
    check("rst_stall", bus.stall, 0);
    check("rst_cache_re", bus.cache_re, 0);
    step();
    check("rst_miss_count", miss_count, 0);
    check("rst_err", err, 0);
    do_reset();

    // Clean write miss
    run_miss(1'b1, 32'h0000_4012, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    check("wm_stall_cycles", r_stall, 22);
    check("wm_end_cycle", r_end, 22);
    check("wm_we2_count", r_we2_n, 1);
    check("wm_we2_cycle", r_we2_cyc, 21);
    check("wm_we3_count", r_we3_n, 0);
    check("wm_wb_count", r_wb_n, 0);
    check("wm_fill_addr", r_fill_addr, 32'h0000_4012);
    check("wm_replay_we", r_rep_we, 1);
    check("wm_replay_re", r_rep_re, 0);
    check("wm_replay_addr", r_rep_addr, 32'h0000_4012);
    check("wm_replay_wdata", r_rep_wdata, 32'h1234_5678);
    check("wm_miss_count", miss_count, 1);

    // Read hit
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h0000_4012; bus.hit = 1'b1;
    #2;
    check("rh_cache_re", bus.cache_re, 1);
    check("rh_cache_addr", bus.cache_addr, 32'h0000_4012);
    check("rh_stall", bus.stall, 0);
    check("rh_strobes", {bus.we2, bus.we3, bus.mem_wb_we}, 0);
    step();
    idle_inputs();
    #2;
    check("rh_stall_after", bus.stall, 0);
    check("rh_miss_count", miss_count, 1);
    step();

    // Dirty read miss
    run_miss(1'b0, 32'h0000_8012, 32'h0, 1'b1, 32'h0000_4010, 1'b1);
    check("dm_wb_count", r_wb_n, 1);
    check("dm_wb_cycle", r_wb_cyc, 1);
    check("dm_wb_addr", r_wb_addr, 32'h0000_4010);
    check("dm_we3_count", r_we3_n, 1);
    check("dm_we3_cycle", r_we3_cyc, 41);
    check("dm_we2_count", r_we2_n, 0);
    check("dm_fill_addr", r_fill_addr, 32'h0000_8012);
    check("dm_end_cycle", r_end, 42);
    check("dm_stall_cycles", r_stall, 42);
    check("dm_replay_re", r_rep_re, 1);
    check("dm_replay_addr", r_rep_addr, 32'h0000_8012);
    check("dm_miss_count", miss_count, 2);
    check("dm_err", err, 0);

    // Reset asserted in cycle 10 of a clean FILL
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h0000_0100;
    step();
    idle_inputs();
    for (int c = 1; c < 10; c++) step();
    #2;
    check("rf_stall_before", bus.stall, 1);
    reset_n = 1'b0;
    #1;
    check("rf_stall_in_reset", bus.stall, 0);
    step();
    reset_n = 1'b1;
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h0000_0200; bus.hit = 1'b1;
    #2;
    check("rf_idle_passthru", bus.cache_re, 1);
    check("rf_stall", bus.stall, 0);
    check("rf_miss_count", miss_count, 0);
    step();
    idle_inputs();
    pulses = 0;
    stalls = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (bus.we2 || bus.we3) pulses++;
      if (bus.stall) stalls++;
      step();
    end
    check("rf_no_fill_pulse", pulses, 0);
    check("rf_no_stall", stalls, 0);

    // Replay that still misses
    run_miss(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    check("rm_end_cycle", r_end, 22);
    check("rm_stall_cycles", r_stall, 22);
    check("rm_err_during_replay", r_rep_err, 0);
    check("rm_err_set", err, 1);
    #2;
    check("rm_idle_stall", bus.stall, 0);
    for (int c = 0; c < 3; c++) step();
    check("rm_err_sticky", err, 1);
    check("rm_miss_count", miss_count, 1);

    // Simultaneous load and store on a hit
    do_reset();
    #2;
    check("il_err_clear", err, 0);
    bus.cpu_re = 1'b1; bus.cpu_we = 1'b1; bus.hit = 1'b1;
    bus.cpu_addr = 32'h0000_4012; bus.cpu_wdata = 32'hA5A5_0001;
    #1;
    check("il_cache_we", bus.cache_we, 1);
    check("il_cache_re", bus.cache_re, 0);
    check("il_stall", bus.stall, 0);
    step();
    idle_inputs();
    check("il_err", err, 1);
    check("il_miss_count", miss_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequencing FSM between the pipeline memory stage and memory_system (cache + main memory).
- Forwards load/store requests to the cache and stalls the pipeline on a miss.
- On a dirty miss, writes the victim back to main memory. Waits the main-memory latency, then issues the single-cycle refill strobes (we2 for write-miss allocate, we3 for read-miss fill) and replays the access.
- Replaces the hand-timed we2/we3 pulses with a deterministic controller.

Parameters:
- MEM_LATENCY, 20, main-memory access time in cycles (one 200 ns access at 10 ns clock); legal range 1..255.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset (sampled on rising clk edge).
- cpu_re  in  1  pipeline load request.
- cpu_we  in  1  pipeline store request.
- cpu_addr  in  32  request byte address.
- cpu_wdata  in  32  store data.
- hit  in  1  cache hit, combinational from memory_system for the presented address.
- dirty  in  1  selected victim line is dirty (valid together with hit).
- victim_addr  in  32  address of the line to be evicted.
- cache_re  out  1  read strobe to memory_system.
- cache_we  out  1  write strobe to memory_system.
- cache_addr  out  32  address to memory_system.
- cache_wdata  out  32  write data to memory_system.
- we2  out  1  write-miss allocate/fill strobe, one cycle.
- we3  out  1  read-miss fill strobe, one cycle.
- mem_wb_we  out  1  victim writeback strobe to main memory, one cycle.
- mem_wb_addr  out  32  writeback address.
- stall  out  1  freeze pipeline memory stage.
- err  out  1  sticky: replay missed, or re and we were both high.
- miss_count  out  CNT_W  saturating count of misses since reset.

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, counter=0, latched request cleared, miss_count=0, err=0.
  - All strobes 0 and stall=0 while in reset.
  - Reset mid-miss aborts the miss; no we2/we3/mem_wb_we is emitted afterwards.
- States: IDLE, WRITEBACK, FILL, REFILL, REPLAY.
- IDLE:
  - cache_addr/cache_wdata/cache_re/cache_we pass through cpu_* combinationally.
  - Request is req = cpu_re|cpu_we.
  - req & hit: access completes in this cycle, stall=0, stay IDLE.
  - req & !hit: stall=1 combinationally. Latch addr, wdata, op (store if cpu_we) and victim_addr. miss_count++ (saturates at all-ones).
    - Next state is WRITEBACK if dirty, else FILL.
  - cpu_re & cpu_we together: store takes priority and err is set.
- WRITEBACK:
  - mem_wb_we=1 and mem_wb_addr=latched victim in the first cycle only.
  - Stays exactly MEM_LATENCY cycles, then goes to FILL.
- FILL: stays exactly MEM_LATENCY cycles, then goes to REFILL.
- REFILL:
  - One cycle with cache_addr=latched addr.
  - we2=1 if the latched op is a store, else we3=1; never both.
  - Then goes to REPLAY.
- REPLAY:
  - Re-issues the latched op (cache_re or cache_we, with latched addr/wdata).
  - If hit, stall=0 this cycle (the pipeline advances at this edge) and the next state is IDLE.
  - If !hit, set err, stall=0 and go to IDLE; the access is not retried.
- stall is 1 in WRITEBACK, FILL and REFILL. While stalled, cpu_* inputs are ignored.
- Latency counter:
  - 8-bit, loaded with MEM_LATENCY-1 on entering WRITEBACK/FILL.
  - Decrements each cycle; the state exits when the counter is 0 and is never reloaded mid-phase.
- Stall length per access (stall-high cycles):
  - Hit: 0.
  - Clean miss: MEM_LATENCY+2.
  - Dirty miss: 2*MEM_LATENCY+2.
- Outside the states named above, all strobes are 0.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state enum (IDLE, WRITEBACK, FILL, REFILL, REPLAY);
  - op encoding (OP_LOAD, OP_STORE);
  - localparam LAT_W=8.
- One sub-module, latency_timer (load, value, tick, done), is natural and reusable by the main-memory model.
- FSM, request latch and miss counter stay in cache_miss_controller.

Test Plan:
- Write miss, clean: cpu_we=1, addr 0x00004012, data 0x12345678, hit=0, dirty=0, MEM_LATENCY=20.
  - Required: stall high for 22 cycles; we2 single pulse in cycle 21 with cache_addr 0x00004012; replay cache_we with 0x12345678 in cycle 22, stall=0; miss_count=1.
- Read hit: cpu_re=1, addr 0x00004012, hit=1.
  - Required: cache_re=1 the same cycle, stall never asserts, we2/we3/mem_wb_we stay 0, miss_count unchanged.
- Read miss, dirty: cpu_re=1, addr 0x00008012, hit=0, dirty=1, victim 0x00004010.
  - Required: mem_wb_we pulse in cycle 1 with mem_wb_addr 0x00004010; we3 pulse in cycle 41; stall deasserts in cycle 42; we2 never asserted.
- Reset mid-fill: reset_n=0 for 1 cycle at cycle 10 of a FILL.
  - Required: next cycle IDLE, stall=0, miss_count=0, and no we2/we3 pulse in the following 30 cycles.
- Replay miss: hold hit=0 through the REPLAY cycle.
  - Required: err=1 and sticky, return to IDLE with stall=0.
- Illegal request: cpu_re=cpu_we=1 on a hit.
  - Required: cache_we=1, cache_re=0, err=1.
